// File: rtl/wait_time_calc_pkg.sv
// Shared types and helpers for the wait-time estimator and its divider.
package wait_time_calc_pkg;

  localparam int DEF_P_W = 3;
  localparam int DEF_T_W = 2;
  localparam int DEF_S_W = 2;
  localparam int DEF_W_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wait_time_calc_seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per cycle, MSB first, N cycles after load.
module seq_divider
  import wait_time_calc_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);

  logic [N-1:0]     rem;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic [N:0]       trial;
  logic             fit;
  logic [N-1:0]     rem_next;
  logic [N-1:0]     acc_next;

  // acc starts as the dividend and fills with quotient bits from the right.
  always_comb begin
    trial    = {rem, acc[N-1]};
    fit      = (trial >= {1'b0, divisor});
    rem_next = fit ? N'(trial - {1'b0, divisor}) : trial[N-1:0];
    acc_next = {acc[N-2:0], fit};
  end

  // done marks the final iteration; quotient is complete in that same cycle.
  assign done     = busy && (cnt == '0);
  assign quotient = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      rem  <= '0;
      acc  <= dividend;
      cnt  <= CNT_W'(N - 1);
      busy <= 1'b1;
    end else if (busy) begin
      rem <= rem_next;
      acc <= acc_next;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/wait_time_calc.sv
// Estimated wait = floor(svc_time * (pcount + tcount - 1) / tcount), saturated to W_W bits.
module wait_time_calc
  import wait_time_calc_pkg::*;
#(
  parameter int P_W = DEF_P_W,
  parameter int T_W = DEF_T_W,
  parameter int S_W = DEF_S_W,
  parameter int W_W = DEF_W_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [P_W-1:0] pcount,
  input  logic [T_W-1:0] tcount,
  input  logic [S_W-1:0] svc_time,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_W-1:0] wait_time,
  output logic           sat,
  output logic           err,
  output logic [1:0]     dbg_state
);

  localparam int NUM_W = S_W + max_int(P_W, T_W) + 1;
  localparam int QX_W  = max_int(NUM_W, W_W);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE and held until out_ready.
  state_t state, next_state;

  logic [P_W-1:0]   p_q;
  logic [T_W-1:0]   t_q;
  logic [S_W-1:0]   s_q;
  logic [NUM_W-1:0] numerator;
  logic             div_load;
  logic             div_busy;
  logic             div_done;
  logic [NUM_W-1:0] quotient;
  logic [QX_W-1:0]  q_ext;
  logic             sat_next;

  // t_q >= 1 whenever this feeds the divider, so the subtraction cannot wrap.
  assign numerator = NUM_W'(s_q) * (NUM_W'(p_q) + NUM_W'(t_q) - NUM_W'(1));
  assign q_ext     = QX_W'(quotient);
  assign sat_next  = (q_ext > QX_W'({W_W{1'b1}}));

  seq_divider #(.N(NUM_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (numerator),
    .divisor  (NUM_W'(t_q)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_comb begin
    next_state = state;
    div_load   = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = MUL;
      end
      MUL: begin
        if (t_q == '0) begin
          next_state = DONE;
        end else begin
          div_load   = 1'b1;
          next_state = DIV;
        end
      end
      DIV: begin
        if (div_done) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p_q       <= '0;
      t_q       <= '0;
      s_q       <= '0;
      wait_time <= '0;
      sat       <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && in_valid) begin
        p_q <= pcount;
        t_q <= tcount;
        s_q <= svc_time;
      end
      if (state == MUL && t_q == '0) begin
        wait_time <= '1;
        sat       <= 1'b0;
        err       <= 1'b1;
      end
      if (state == DIV && div_done) begin
        wait_time <= sat_next ? {W_W{1'b1}} : q_ext[W_W-1:0];
        sat       <= sat_next;
        err       <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule
